// File: rtl/core_seq_if.sv
// Command/status bundle between a host controller and the core_seq sequencer.
// Latency: none (plain wires); every core-driven signal is registered inside core_seq.
// Backpressure: ofifo_valid gates the drain phase; start is ignored while busy.
interface core_seq_if #(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 11,
  parameter int TILE_W = 8
);
  localparam int IW = 13 + 2 * ADDR_W;

  // command side
  logic              start;
  logic              abort;
  logic              mode;
  logic              relu_en;
  logic [LEN_W-1:0]  len;
  logic [TILE_W-1:0] num_tiles;
  logic [ADDR_W-1:0] xmem_base;
  logic [ADDR_W-1:0] pmem_base;
  logic              ofifo_valid;

  // sequencer side
  logic [IW-1:0]     inst;
  logic              busy;
  logic              done;
  logic [TILE_W-1:0] tile_idx;

  modport master (
    output start, abort, mode, relu_en, len, num_tiles, xmem_base, pmem_base, ofifo_valid,
    input  inst, busy, done, tile_idx
  );

  modport slave (
    input  start, abort, mode, relu_en, len, num_tiles, xmem_base, pmem_base, ofifo_valid,
    output inst, busy, done, tile_idx
  );
endinterface

// File: rtl/core_seq.sv
// Tile sequencer for a ROW x COL PE array: emits one registered instruction word per cycle.
// Latency: inst lags the FSM by one cycle; done pulses in the first IDLE cycle after the last write.
// Backpressure: drain stalls while ofifo_valid is low; start is only honoured in IDLE.
module core_seq #(
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 11,
  parameter int TILE_W = 8
) (
  input  logic      clk,
  input  logic      reset,
  core_seq_if.slave bus
);

  localparam int IW = 13 + 2 * ADDR_W;
  localparam int CW = ((LEN_W > $clog2(ROW + 1)) ? LEN_W : $clog2(ROW + 1)) + 1;

  // instruction field positions
  localparam int B_LOAD = 0;
  localparam int B_EXEC = 1;
  localparam int B_L0WR = 2;
  localparam int B_L0RD = 3;
  localparam int B_OFRD = 6;
  localparam int XA_LO  = 7;
  localparam int XA_HI  = 6 + ADDR_W;
  localparam int B_XWEN = 7 + ADDR_W;
  localparam int B_XCEN = 8 + ADDR_W;
  localparam int PA_LO  = 9 + ADDR_W;
  localparam int PA_HI  = 8 + 2 * ADDR_W;
  localparam int B_PWEN = 9 + 2 * ADDR_W;
  localparam int B_PCEN = 10 + 2 * ADDR_W;
  localparam int B_ACC  = 11 + 2 * ADDR_W;
  localparam int B_RELU = 12 + 2 * ADDR_W;

  // both SRAMs deselected and write-disabled, everything else quiet
  localparam logic [IW-1:0] IDLE_INST = (IW'(1) << B_XWEN) | (IW'(1) << B_XCEN) |
                                        (IW'(1) << B_PWEN) | (IW'(1) << B_PCEN);

  localparam logic [CW-1:0]     ONE  = CW'(1);
  localparam logic [TILE_W-1:0] TONE = TILE_W'(1);

  // a degenerate array shape is a configuration error, not a runtime condition
  if (ROW < 1 || COL < 1) begin : g_bad_shape
    $error("core_seq: ROW and COL must both be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_WPROP, S_XLOAD, S_EXEC, S_DRAIN, S_NEXT
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;    // per-phase cycle / read counter
  logic [CW-1:0]     pcnt;   // pops issued this drain
  logic [CW-1:0]     wcnt;   // pmem writes issued this drain
  logic [ADDR_W-1:0] rptr;   // running xmem read pointer, carried across tiles

  // command parameters, frozen for the whole command
  logic              mode_q;
  logic              relu_q;
  logic [LEN_W-1:0]  len_q;
  logic [TILE_W-1:0] num_q;
  logic [ADDR_W-1:0] pbase_q;

  logic [IW-1:0]     inst_q;
  logic              busy_q;
  logic              done_q;
  logic [TILE_W-1:0] tile_q;

  logic [CW-1:0]     len_c;
  logic [CW-1:0]     load_lim;
  logic              last_tile;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  // WLOAD streams a ROW-deep weight tile, XLOAD a len-deep activation tile
  assign len_c     = CW'(len_q);
  assign load_lim  = (state == S_WLOAD) ? CW'(ROW) : len_c;
  assign last_tile = (tile_q == num_q - TONE);
  assign rd_addr   = rptr + ADDR_W'(cnt);
  assign wr_addr   = pbase_q + ADDR_W'(wcnt);

  assign bus.inst     = inst_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tile_idx = tile_q;

  // sequencer FSM; every output is registered here alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pcnt    <= '0;
      wcnt    <= '0;
      rptr    <= '0;
      mode_q  <= 1'b0;
      relu_q  <= 1'b0;
      len_q   <= '0;
      num_q   <= '0;
      pbase_q <= '0;
      inst_q  <= IDLE_INST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tile_q  <= '0;
    end else if (bus.abort) begin
      // abandon the command; any write pending from the last pop is dropped
      state  <= S_IDLE;
      cnt    <= '0;
      pcnt   <= '0;
      wcnt   <= '0;
      inst_q <= IDLE_INST;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tile_q <= '0;
    end else begin
      done_q <= 1'b0;
      inst_q <= IDLE_INST;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mode_q  <= bus.mode;
            relu_q  <= bus.relu_en;
            len_q   <= bus.len;
            num_q   <= bus.num_tiles;
            pbase_q <= bus.pmem_base;
            rptr    <= bus.xmem_base;
            tile_q  <= '0;
            cnt     <= '0;
            if (bus.len == '0 || bus.num_tiles == '0) begin
              // empty command: acknowledge without touching memory
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              state  <= bus.mode ? S_XLOAD : S_WLOAD;
            end
          end
        end

        S_WLOAD, S_XLOAD: begin
          // SRAM data arrives one cycle after its read, so L0 write trails the read
          inst_q[B_L0WR] <= ~inst_q[B_XCEN];
          if (cnt < load_lim) begin
            inst_q[B_XCEN]      <= 1'b0;
            inst_q[XA_HI:XA_LO] <= rd_addr;
            cnt                 <= cnt + ONE;
          end else begin
            // this cycle carries only the trailing L0 write
            cnt   <= '0;
            rptr  <= rptr + ADDR_W'(load_lim);
            state <= (state == S_WLOAD) ? S_WPROP : S_EXEC;
          end
        end

        S_WPROP: begin
          inst_q[B_LOAD] <= 1'b1;
          inst_q[B_L0RD] <= 1'b1;
          if (cnt == CW'(ROW - 1)) begin
            cnt   <= '0;
            state <= S_XLOAD;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        S_EXEC: begin
          inst_q[B_EXEC] <= 1'b1;
          inst_q[B_L0RD] <= 1'b1;
          if (cnt + ONE == len_c) begin
            cnt   <= '0;
            pcnt  <= '0;
            wcnt  <= '0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        S_DRAIN: begin
          // pop only while rows remain; the fifo is never over-read
          if (bus.ofifo_valid && pcnt < len_c) begin
            inst_q[B_OFRD] <= 1'b1;
            pcnt           <= pcnt + ONE;
          end
          // the row popped last cycle is now on the fifo output: store it
          if (inst_q[B_OFRD]) begin
            inst_q[B_PCEN]      <= 1'b0;
            inst_q[B_PWEN]      <= 1'b0;
            inst_q[PA_HI:PA_LO] <= wr_addr;
            inst_q[B_ACC]       <= (tile_q != '0);
            inst_q[B_RELU]      <= relu_q && last_tile;
            wcnt                <= wcnt + ONE;
            if (wcnt + ONE == len_c) begin
              state <= S_NEXT;
            end
          end
        end

        S_NEXT: begin
          if (last_tile) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            tile_q <= tile_q + TONE;
            cnt    <= '0;
            state  <= mode_q ? S_XLOAD : S_WLOAD;
          end
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: drives commands through the interface and checks the instruction stream.
// Latency: inputs change 1 time unit after a rising edge; a negedge monitor logs every instruction word.
// Backpressure: ofifo_valid is driven per test to stall and release the drain phase.
module tb_core_seq;

  // instruction layout at ADDR_W = 11 (35-bit word)
  localparam int B_LOAD = 0;
  localparam int B_EXEC = 1;
  localparam int B_L0WR = 2;
  localparam int B_OFRD = 6;
  localparam int B_XCEN = 19;
  localparam int B_PWEN = 31;
  localparam int B_PCEN = 32;
  localparam int B_ACC  = 33;
  localparam int B_RELU = 34;
  localparam logic [34:0] IDLE_INST = 35'h1_800C_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  core_seq_if bus ();
  core_seq dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- instruction monitor ----------------
  bit          mon_en = 1'b0;
  int          n_load = 0, n_exec = 0, n_l0wr = 0, n_pop = 0, n_done = 0, n_busy = 0;
  int          bad_l0wr = 0, bad_pw = 0, bad_idle = 0;
  logic [10:0] rd_q[$];
  logic [10:0] wr_a[$];
  logic        wr_acc[$];
  logic        wr_relu[$];
  logic        xrd, pw;
  logic        prev_xrd = 1'b0, prev_pop = 1'b0, kill_d = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      xrd = !bus.inst[B_XCEN];
      pw  = !bus.inst[B_PCEN] && !bus.inst[B_PWEN];
      if (xrd) rd_q.push_back(bus.inst[17:7]);
      if (pw) begin
        wr_a.push_back(bus.inst[30:20]);
        wr_acc.push_back(bus.inst[B_ACC]);
        wr_relu.push_back(bus.inst[B_RELU]);
      end
      if (bus.inst[B_L0WR]) n_l0wr++;
      if (bus.inst[B_LOAD]) n_load++;
      if (bus.inst[B_EXEC]) n_exec++;
      if (bus.inst[B_OFRD]) n_pop++;
      if (bus.done) n_done++;
      if (bus.busy) n_busy++;
      if (!reset && !kill_d) begin
        if (bus.inst[B_L0WR] !== prev_xrd) bad_l0wr++;
        if (pw !== prev_pop) bad_pw++;
      end
      if (!bus.busy && bus.inst !== IDLE_INST) bad_idle++;
      prev_xrd = xrd;
      prev_pop = bus.inst[B_OFRD];
      kill_d   = reset || bus.abort;
    end
  end

  // ---------------- helpers ----------------
  int b_rd, b_wr, b_load, b_exec, b_l0wr, b_pop, b_done, b_busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_rd = rd_q.size();  b_wr = wr_a.size();  b_load = n_load;  b_exec = n_exec;
    b_l0wr = n_l0wr;     b_pop = n_pop;       b_done = n_done;  b_busy = n_busy;
  endtask

  task automatic issue(input logic m, input logic r, input int ln, input int nt,
                       input int xb, input int pb);
    bus.mode      = m;
    bus.relu_en   = r;
    bus.len       = 11'(ln);
    bus.num_tiles = 8'(nt);
    bus.xmem_base = 11'(xb);
    bus.pmem_base = 11'(pb);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (!bus.done && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_done_seen"}, bus.done, 1);
    tick();
    tick();
  endtask

  task automatic wait_exec(input int n);
    int c = 0;
    while (n_exec - b_exec < n && c < 300) begin
      tick();
      c++;
    end
    chk("exec_reached", (n_exec - b_exec >= n), 1);
  endtask

  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0; bus.relu_en = 1'b0;
    bus.len = '0; bus.num_tiles = '0; bus.xmem_base = '0; bus.pmem_base = '0;
    bus.ofifo_valid = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_inst", bus.inst, IDLE_INST);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tile", bus.tile_idx, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // WS, len 4, one tile
    snap();
    bus.ofifo_valid = 1'b1;
    issue(1'b0, 1'b0, 4, 1, 'h010, 'h100);
    chk("t1_busy", bus.busy, 1);
    wait_done("t1", 200);
    chk("t1_nrd", rd_q.size() - b_rd, 12);
    for (int i = 0; i < 12; i++) chk("t1_rd", rd_q[b_rd + i], 'h010 + i);
    chk("t1_l0wr", n_l0wr - b_l0wr, 12);
    chk("t1_load", n_load - b_load, 8);
    chk("t1_exec", n_exec - b_exec, 4);
    chk("t1_pop", n_pop - b_pop, 4);
    chk("t1_nwr", wr_a.size() - b_wr, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_wa", wr_a[b_wr + i], 'h100 + i);
      chk("t1_acc", wr_acc[b_wr + i], 0);
      chk("t1_relu", wr_relu[b_wr + i], 0);
    end
    chk("t1_ndone", n_done - b_done, 1);
    chk("t1_idle_busy", bus.busy, 0);

    // OS, len 3, two tiles, relu; a second start mid-command must be ignored
    snap();
    issue(1'b1, 1'b1, 3, 2, 'h020, 'h200);
    tick();
    bus.start = 1'b1; bus.mode = 1'b0; bus.len = 11'd9;
    tick();
    bus.start = 1'b0;
    wait_done("t2", 300);
    chk("t2_nrd", rd_q.size() - b_rd, 6);
    for (int i = 0; i < 6; i++) chk("t2_rd", rd_q[b_rd + i], 'h020 + i);
    chk("t2_load", n_load - b_load, 0);
    chk("t2_exec", n_exec - b_exec, 6);
    chk("t2_nwr", wr_a.size() - b_wr, 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_wa", wr_a[b_wr + i], 'h200 + (i % 3));
      chk("t2_acc", wr_acc[b_wr + i], (i >= 3));
      chk("t2_relu", wr_relu[b_wr + i], (i >= 3));
    end
    chk("t2_ndone", n_done - b_done, 1);

    // empty commands: len 0, then num_tiles 0
    snap();
    issue(1'b0, 1'b0, 0, 3, 'h040, 'h300);
    chk("t3_done", bus.done, 1);
    chk("t3_busy", bus.busy, 0);
    tick();
    chk("t3_done_clr", bus.done, 0);
    issue(1'b1, 1'b0, 5, 0, 'h040, 'h300);
    chk("t3b_done", bus.done, 1);
    tick();
    tick();
    chk("t3_nrd", rd_q.size() - b_rd, 0);
    chk("t3_nbusy", n_busy - b_busy, 0);
    chk("t3_ndone", n_done - b_done, 2);

    // drain stall and ofifo_valid pattern 1,0,0,1,1,1
    snap();
    bus.ofifo_valid = 1'b0;
    issue(1'b0, 1'b0, 4, 1, 'h050, 'h400);
    wait_exec(4);
    repeat (3) tick();
    chk("t4_stall_pop", n_pop - b_pop, 0);
    chk("t4_stall_wr", wr_a.size() - b_wr, 0);
    chk("t4_stall_busy", bus.busy, 1);
    for (int i = 0; i < 6; i++) begin
      bus.ofifo_valid = pat[i];
      tick();
    end
    bus.ofifo_valid = 1'b1;
    wait_done("t4", 100);
    chk("t4_pop", n_pop - b_pop, 4);
    chk("t4_nwr", wr_a.size() - b_wr, 4);
    for (int i = 0; i < 4; i++) chk("t4_wa", wr_a[b_wr + i], 'h400 + i);

    // xmem address wrap
    snap();
    issue(1'b0, 1'b0, 2, 1, 'h7FE, 'h010);
    wait_done("t5", 200);
    chk("t5_nrd", rd_q.size() - b_rd, 10);
    chk("t5_rd0", rd_q[b_rd + 0], 'h7FE);
    chk("t5_rd1", rd_q[b_rd + 1], 'h7FF);
    chk("t5_rd2", rd_q[b_rd + 2], 'h000);
    chk("t5_rd9", rd_q[b_rd + 9], 'h007);
    chk("t5_wa0", wr_a[b_wr + 0], 'h010);
    chk("t5_wa1", wr_a[b_wr + 1], 'h011);

    // abort during EXEC
    snap();
    issue(1'b0, 1'b0, 2, 1, 'h000, 'h000);
    wait_exec(1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t6_busy", bus.busy, 0);
    chk("t6_inst", bus.inst, IDLE_INST);
    chk("t6_done", bus.done, 0);
    repeat (5) tick();
    chk("t6_ndone", n_done - b_done, 0);
    chk("t6_nwr", wr_a.size() - b_wr, 0);

    // synchronous reset mid-DRAIN with a write pending
    snap();
    bus.ofifo_valid = 1'b0;
    issue(1'b0, 1'b0, 2, 1, 'h100, 'h500);
    wait_exec(2);
    tick();
    tick();
    bus.ofifo_valid = 1'b1;
    tick();
    chk("t7_pop", bus.inst[B_OFRD], 1);
    reset = 1'b1;
    tick();
    chk("t7_inst", bus.inst, IDLE_INST);
    chk("t7_busy", bus.busy, 0);
    chk("t7_done", bus.done, 0);
    chk("t7_tile", bus.tile_idx, 0);
    reset = 1'b0;
    bus.ofifo_valid = 1'b0;
    repeat (4) tick();
    chk("t7_ndone", n_done - b_done, 0);
    chk("t7_nwr", wr_a.size() - b_wr, 0);

    // timing invariants across the whole run
    chk("l0wr_timing", bad_l0wr, 0);
    chk("pmem_timing", bad_pw, 0);
    chk("idle_inst", bad_idle, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter ROW, default 8: PE array rows; weight vectors loaded per tile.
REQ-002 Parameter COL, default 8: PE array columns; informational, shapes no port.
REQ-003 Parameter ADDR_W, default 11: xmem/pmem address width; inst width IW = 13+2*ADDR_W (35 at default).
REQ-004 Parameter LEN_W, default 11: width of len.
REQ-005 Parameter TILE_W, default 8: width of num_tiles and tile_idx.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 start  in  1  one-cycle command pulse, sampled only in IDLE.
REQ-009 abort  in  1  return to IDLE next cycle from any state.
REQ-010 mode  in  1  0=weight-stationary (WS), 1=output-stationary (OS); sampled with start.
REQ-011 relu_en  in  1  assert relu bit during last-tile drain; sampled with start.
REQ-012 len  in  LEN_W  activation vectors per tile; sampled with start.
REQ-013 num_tiles  in  TILE_W  tiles per command; sampled with start.
REQ-014 xmem_base, pmem_base  in  ADDR_W each  start addresses; sampled with start.
REQ-015 ofifo_valid  in  1  output FIFO holds a row of partial sums.
REQ-016 inst  out  IW  registered instruction word (field map below).
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse on command completion.
REQ-019 tile_idx  out  TILE_W  tile in progress, 0-based.
REQ-020 inst fields: [0] load, [1] execute, [2] l0_wr, [3] l0_rd, [5:4] reserved 0, [6] ofifo_rd, [6+A:7] xmem addr, [7+A] xmem WEN, [8+A] xmem CEN, [8+2A:9+A] pmem addr, [9+2A] pmem WEN, [10+2A] pmem CEN, [11+2A] acc, [12+2A] relu (A=ADDR_W).

Function
REQ-021 IDLE inst: both CEN=1, both WEN=1, addresses 0, all other bits 0.
REQ-022 States: IDLE, WLOAD, WPROP, XLOAD, EXEC, DRAIN, NEXT.
REQ-023 IDLE + start: len=0 or num_tiles=0 -> stay IDLE, done pulses next cycle; else mode=0 -> WLOAD, mode=1 -> XLOAD; rptr <= xmem_base, tile_idx <= 0.
REQ-024 WLOAD, ROW cycles: xmem CEN=0 WEN=1 addr=rptr+k (k=0..ROW-1); l0_wr high exactly one cycle after each read (1-cycle SRAM latency); rptr advances ROW; exit after last l0_wr.
REQ-025 WPROP, ROW cycles: load=1, l0_rd=1; then XLOAD.
REQ-026 XLOAD, len cycles: same read/l0_wr protocol as WLOAD over rptr..rptr+len-1; rptr advances len.
REQ-027 EXEC, len cycles: execute=1, l0_rd=1; then DRAIN.
REQ-028 DRAIN: ofifo_rd=1 in any cycle with ofifo_valid=1 and pops<len; pmem CEN=0 WEN=0 exactly one cycle after each pop, addr=pmem_base+j (j=0..len-1, same addresses every tile).
REQ-029 DRAIN: acc=1 on every pmem write when tile_idx>0; relu=1 on every pmem write when tile_idx=num_tiles-1 and relu_en=1.
REQ-030 DRAIN -> NEXT after len-th pmem write; NEXT: last tile -> IDLE with done=1 same cycle; else tile_idx+1 and WLOAD (WS) or XLOAD (OS).
REQ-031 ofifo_valid low in DRAIN: stall indefinitely, inst idle apart from pending write.
REQ-032 Address arithmetic modulo 2^ADDR_W; wrap silent.
REQ-033 start while busy ignored; parameters held for whole command.
REQ-034 abort: next cycle IDLE, inst idle, busy=0, no done; pending pmem write dropped.
REQ-035 inst, busy, done, tile_idx all registered; no combinational input-to-output paths.

Reset
REQ-036 reset: state IDLE, inst per REQ-021, busy=0, done=0, tile_idx=0, counters/pointers 0; overrides start and abort; mid-command reset aborts with no done.

Verification
REQ-037 WS, len=4, num_tiles=1, xmem_base=0x010, pmem_base=0x100, ofifo_valid=1 -> reads 0x010-0x017, 8 WPROP cycles, reads 0x018-0x01B, 4 EXEC cycles, writes 0x100-0x103 acc=0, done once.
REQ-038 OS, len=3, num_tiles=2, relu_en=1 -> no WLOAD/WPROP; tile1 reads base+3..+5; tile1 writes acc=1 relu=1; tile0 acc=0 relu=0.
REQ-039 start with len=0 -> no CEN=0 cycle, done one cycle later, busy stays 0.
REQ-040 DRAIN, ofifo_valid toggled 1,0,0,1,1,1 with len=4 -> exactly 4 pops, 4 writes, each one cycle after its pop.
REQ-041 xmem_base=0x7FE, WS, len=2 -> reads wrap 0x7FE,0x7FF,0x000...; abort in EXEC -> IDLE next cycle, no done; sync reset mid-DRAIN -> IDLE, inst idle.
